// File: rtl/joystick_pkg.sv
// Shared definitions for the joystick ADC reader and its downstream display/servo stages.
package joystick_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_WAIT
  } state_t;

  localparam int POS_W           = 10;
  localparam int FRAME_BITS      = 17;
  localparam int DATA_FIRST_EDGE = 8;
  localparam int CMD_BITS        = 5;

  localparam logic [POS_W-1:0] POS_CENTER = 10'd528;
  localparam logic [POS_W-1:0] POS_MIN    = 10'd228;
  localparam logic [POS_W-1:0] POS_MAX    = 10'd830;

  // Command bit presented on DIN before rising edge idx: start, single-ended, D2, D1, D0.
  function automatic logic cmd_bit(input logic [4:0] idx, input logic [2:0] ch);
    logic b;
    case (idx)
      5'd1:    b = 1'b1;
      5'd2:    b = 1'b1;
      5'd3:    b = ch[2];
      5'd4:    b = ch[1];
      5'd5:    b = ch[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/joystick_adc_reader_spi_tick_gen.sv
// SCLK half-period strobe: one-cycle tick every CLK_DIV clocks while run is high.
module spi_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Counter restarts from zero each time the frame machine leaves IDLE/WAIT.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == CNT_LAST);

endmodule

// File: rtl/joystick_adc_reader.sv
// Joystick axis reader: periodic MCP3008 SPI conversion published on pos/pos_valid.
// Build option: define AVERAGE_EN to publish the truncated mean of each 2**AVG_LOG2 frames.
module joystick_adc_reader #(
  parameter int CLK_DIV       = 25,
  parameter int CHANNEL       = 0,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AVG_LOG2      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic [9:0] pos,
  output logic       pos_valid,
  output logic       busy
);

  import joystick_pkg::*;

  if (CLK_DIV < 2 || CHANNEL < 0 || CHANNEL > 7 || SAMPLE_PERIOD < 1 || AVG_LOG2 < 0) begin : g_param_check
    $error("joystick_adc_reader: parameter out of range");
  end

  localparam int PER_W = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [2:0] CH = 3'(CHANNEL);

  state_t            state;
  logic              tick;
  logic              run;
  logic              phase;
  logic [4:0]        fall_cnt;
  logic [4:0]        rise_num;
  logic [POS_W-1:0]  shreg;
  logic [PER_W-1:0]  per_cnt;
  logic              start_frame;
  logic              frame_done;

  assign run         = (state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD);
  assign rise_num    = fall_cnt + 5'd1;
  assign start_frame = enable && ((state == ST_IDLE) || ((state == ST_WAIT) && (per_cnt == PER_LAST)));
  assign frame_done  = (state == ST_CS_HOLD) && tick && phase;

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  // Frame sequencer: setup and hold each span two ticks, SHIFT spans 34 ticks (17 SCLK periods).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      busy     <= 1'b0;
      phase    <= 1'b0;
      fall_cnt <= '0;
      shreg    <= '0;
      per_cnt  <= '0;
    end else if (start_frame) begin
      state    <= ST_CS_SETUP;
      spi_cs_n <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= cmd_bit(5'd1, CH);
      busy     <= 1'b1;
      phase    <= 1'b0;
      fall_cnt <= '0;
      per_cnt  <= '0;
    end else begin
      if (per_cnt != PER_LAST) begin
        per_cnt <= per_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
        end
        ST_CS_SETUP: begin
          if (tick) begin
            if (phase) begin
              state <= ST_SHIFT;
              phase <= 1'b0;
            end else begin
              phase <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
              if (rise_num >= 5'(DATA_FIRST_EDGE)) begin
                shreg <= {shreg[POS_W-2:0], spi_miso};
              end
            end else begin
              spi_sclk <= 1'b0;
              fall_cnt <= rise_num;
              if (rise_num == 5'(FRAME_BITS)) begin
                state    <= ST_CS_HOLD;
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                phase    <= 1'b0;
              end else begin
                spi_mosi <= cmd_bit(rise_num + 5'd1, CH);
              end
            end
          end
        end
        ST_CS_HOLD: begin
          if (tick) begin
            if (phase) begin
              state <= ST_WAIT;
              busy  <= 1'b0;
              phase <= 1'b0;
            end else begin
              phase <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (per_cnt == PER_LAST) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AVERAGE_EN
  localparam int ACC_W  = POS_W + AVG_LOG2;
  localparam int FCNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'((1 << AVG_LOG2) - 1);

  function automatic logic [POS_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return POS_W'(sum >> AVG_LOG2);
  endfunction

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [FCNT_W-1:0] fcnt;

  assign acc_sum = acc + ACC_W'(shreg);

  // Publish stage: one result per completed block of frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      fcnt      <= '0;
      pos       <= POS_CENTER;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (frame_done) begin
        if (fcnt == FCNT_LAST) begin
          pos       <= avg_trunc(acc_sum);
          pos_valid <= 1'b1;
          acc       <= '0;
          fcnt      <= '0;
        end else begin
          acc  <= acc_sum;
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end
`else
  // Publish stage: every completed frame updates pos with the raw code.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= POS_CENTER;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= frame_done;
      if (frame_done) begin
        pos <= shreg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_joystick_adc_reader.sv
// Bench for joystick_adc_reader: two DUTs (channels 0 and 5) against MCP3008 models and a frame-level scoreboard.
module tb_joystick_adc_reader;

  localparam int C          = 4;
  localparam int P          = 400;
  localparam int FRAME_CLKS = 38 * C;
`ifdef AVERAGE_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct {
    int         due;
    logic [9:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       sclk [2];
  logic       mosi [2];
  logic       cs_n [2];
  logic       busy [2];
  logic       pos_valid [2];
  logic       miso [2] = '{1'b0, 1'b0};
  logic [9:0] pos [2];

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       rst_q = 1'b1;

  logic [9:0] adc_code = 10'd0;
  logic       spacing_on = 1'b0;
  exp_t       exp_q [$];
  logic [9:0] exp_pos = 10'd528;
  logic       exp_v;
  int         blk_sum = 0;
  int         blk_n = 0;
  int         start_cyc = 0;
  int         n_starts = 0;

  logic       cs_d [2] = '{1'b1, 1'b1};
  logic       sclk_d [2] = '{1'b0, 1'b0};
  logic       mosi_d [2] = '{1'b0, 1'b0};
  int         rise_n [2] = '{0, 0};
  int         since [2] = '{0, 0};
  logic       have_edge [2] = '{1'b0, 1'b0};
  logic [4:0] cmd [2];
  logic [9:0] code_lat [2];

  joystick_adc_reader #(.CLK_DIV(C), .CHANNEL(0), .SAMPLE_PERIOD(P), .AVG_LOG2(2)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .spi_miso(miso[0]), .spi_sclk(sclk[0]),
    .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .pos(pos[0]), .pos_valid(pos_valid[0]), .busy(busy[0]));

  joystick_adc_reader #(.CLK_DIV(C), .CHANNEL(5), .SAMPLE_PERIOD(P), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .spi_miso(miso[1]), .spi_sclk(sclk[1]),
    .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .pos(pos[1]), .pos_valid(pos_valid[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  function automatic logic [2:0] ch_of(input int i);
    return (i == 0) ? 3'd0 : 3'd5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ADC models, protocol checks and scoreboard, all sampled on the falling clk edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_q) begin
        exp_q.delete();
        exp_pos = 10'd528;
        blk_sum = 0;
        blk_n   = 0;
        for (int i = 0; i < 2; i++) begin
          check("rst_cs_n", cs_n[i], 1);
          check("rst_sclk", sclk[i], 0);
          check("rst_mosi", mosi[i], 0);
          check("rst_busy", busy[i], 0);
          check("rst_pos_valid", pos_valid[i], 0);
          check("rst_pos", pos[i], 528);
          rise_n[i]    = 0;
          have_edge[i] = 1'b0;
          miso[i]      = 1'b0;
        end
      end else begin
        exp_v = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          exp_v   = 1'b1;
          exp_pos = exp_q[0].val;
          void'(exp_q.pop_front());
        end
        for (int i = 0; i < 2; i++) begin
          check("pos_valid", pos_valid[i], exp_v);
          check("pos", pos[i], exp_pos);
          since[i]++;
          if (cs_d[i] && !cs_n[i]) begin
            rise_n[i]    = 0;
            cmd[i]       = 5'd0;
            have_edge[i] = 1'b0;
            miso[i]      = 1'b0;
            since[i]     = 0;
            code_lat[i]  = adc_code;
            if (i == 0) begin
              if (spacing_on && n_starts > 0) check("frame_spacing", cyc - start_cyc, P);
              start_cyc = cyc;
              n_starts++;
              blk_sum += int'(adc_code);
              blk_n++;
              if (blk_n == (1 << L)) begin
                exp_q.push_back('{due: cyc + FRAME_CLKS, val: 10'(blk_sum >> L)});
                blk_sum = 0;
                blk_n   = 0;
              end
            end
          end
          if (sclk[i] && !sclk_d[i]) begin
            rise_n[i]++;
            if (rise_n[i] <= 5) cmd[i] = {cmd[i][3:0], mosi[i]};
            check("mosi_stable_at_rise", mosi[i], mosi_d[i]);
            if (have_edge[i]) check("sclk_low_time", since[i], C);
            since[i]     = 0;
            have_edge[i] = 1'b1;
          end else if (!sclk[i] && sclk_d[i]) begin
            check("sclk_high_time", since[i], C);
            since[i] = 0;
            if (rise_n[i] >= 7 && rise_n[i] <= 16) miso[i] = code_lat[i][16 - rise_n[i]];
            else miso[i] = 1'b0;
          end
          if (!cs_d[i] && cs_n[i]) begin
            check("sclk_rises_per_frame", rise_n[i], 17);
            check("cmd_bits", cmd[i], {2'b11, ch_of(i)});
          end
          if (cs_n[i]) check("sclk_low_while_cs_high", sclk[i], 0);
        end
      end
      for (int i = 0; i < 2; i++) begin
        cs_d[i]   = cs_n[i];
        sclk_d[i] = sclk[i];
        mosi_d[i] = mosi[i];
      end
    end
  end

  task automatic wait_starts(input int target);
    int n = 0;
    while (n_starts < target && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    if (n_starts < target) check("frame_start_timeout", n_starts, target);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy[0] !== 1'b0 && n < 2 * P) begin
      @(negedge clk);
      n++;
    end
    check("busy_release", busy[0], 0);
  endtask

  initial begin
    int seq [$];
    int ns;
    int n;
    seq = '{228, 230, 231, 233, 700, 0, 1023};
    repeat (5) seq.push_back(int'($urandom_range(1023, 0)));
    ns = 0;

    repeat (4) @(negedge clk);
    adc_code = 10'(seq[0]);
    rst      = 1'b0;
    enable   = 1'b1;
    for (int k = 0; k < seq.size(); k++) begin
      adc_code = 10'(seq[k]);
      ns++;
      wait_starts(ns);
      spacing_on = 1'b1;
      wait_not_busy();
    end

    // enable dropped mid-SHIFT: the frame must finish and no new frame may start
    spacing_on = 1'b0;
    adc_code   = 10'($urandom_range(1023, 0));
    wait_starts(ns + 1);
    ns++;
    repeat (10 * C) @(negedge clk);
    enable = 1'b0;
    wait_not_busy();
    repeat (P + 40) begin
      @(negedge clk);
      check("idle_cs_n", cs_n[0], 1);
      check("idle_cs_n_ch5", cs_n[1], 1);
      check("idle_busy", busy[0], 0);
    end

    // reset at the 9th rising SCLK edge aborts the frame
    adc_code = 10'($urandom_range(1023, 0));
    enable   = 1'b1;
    ns++;
    wait_starts(ns);
    n = 0;
    while (rise_n[0] < 9 && n < FRAME_CLKS) begin
      @(negedge clk);
      n++;
    end
    check("reached_9th_rise", rise_n[0], 9);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    adc_code = 10'($urandom_range(1023, 0));
    rst      = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) adc_code = 10'($urandom_range(1023, 0));
      ns++;
      wait_starts(ns);
      if (k == 3) enable = 1'b0;
      wait_not_busy();
    end
    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
